pulse_gen: RTL
==============

# pulse_gen

Programmable pulse-train generator for the frequency-counter design. It produces a registered square/pulse waveform with a configurable period, high time and burst length, so the measurement path can be driven and checked on-chip with a known frequency. Configuration is captured on a start strobe. The generator then runs either for a fixed number of periods or continuously until stopped.

## Interface
- CNT_W, 32, width of period/high-time counters
- BURST_W, 16, width of burst length and pulse counter
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle strobe; latch config and begin generation
- stop  in  1  single-cycle strobe; abort generation
- period  in  CNT_W  pulse period in clk cycles, sampled only with accepted start
- high_time  in  CNT_W  high phase length in clk cycles, sampled only with accepted start
- burst  in  BURST_W  number of periods to emit; 0 = continuous
- pulse  out  1  generated waveform, registered
- busy  out  1  high while generating
- done  out  1  one-cycle strobe on normal burst completion
- cfg_err  out  1  one-cycle strobe when start is rejected for bad config
- pulse_cnt  out  BURST_W  periods started since last accepted start, wraps modulo 2^BURST_W

## Operation
- Reset values: pulse=0, busy=0, done=0, cfg_err=0, pulse_cnt=0, state=IDLE, all internal counters and latched config 0.
- States: IDLE, HIGH, LOW.
- IDLE + start=1 + stop=0:
  - Config is valid when period≥2 and 1≤high_time<period. If valid: latch period/high_time/burst, clear pulse_cnt to 1, go HIGH.
  - If invalid: assert cfg_err for one cycle, stay IDLE, pulse_cnt unchanged.
- IDLE + start=1 + stop=1: stop wins, start ignored, no cfg_err.
- HIGH: pulse=1. After high_time cycles in HIGH, go LOW.
- LOW: pulse=0. After (period−high_time) cycles in LOW, the period ends:
  - burst=0 or periods emitted < burst: go HIGH, increment pulse_cnt.
  - Otherwise: go IDLE, busy=0, done=1 for that one cycle.
- stop=1 while busy: go IDLE next edge, pulse=0, busy=0. No done is asserted. pulse_cnt holds its value.
- start while busy: ignored, including the cycle where the final LOW ends. Config inputs are don't-care while busy.
- Counters are CNT_W wide with no saturation. period up to 2^CNT_W−1 is legal.
- pulse_cnt wraps in continuous mode. Burst compare uses a separate full-width period counter, not pulse_cnt wrap.
- Asynchronous reset mid-operation returns every output to its reset value immediately. The latched config is discarded.

## Timing
- Start accepted at edge k: pulse=1, busy=1, pulse_cnt=1 from edge k (visible the cycle after start is sampled).
- Rising edges of pulse occur at edges k + n·P, n = 0..B−1 (P = period, H = high_time, B = burst).
- Falling edges occur at k + n·P + H.
- Normal completion: at edge k + B·P, busy=0, pulse=0, done=1. done clears at the next edge.
- Duty is exactly H of every P cycles, with no gap cycle between periods.
- stop sampled at edge j (busy): pulse=0 and busy=0 from edge j.
- cfg_err is asserted from the edge sampling the rejected start, for one cycle.
- All outputs are registered with no combinational path from inputs. Throughput is one configured waveform; the next start is accepted at the earliest one cycle after busy falls.

## Test plan
- Reset: assert rst_n=0 while running with P=4, H=2 → all outputs 0 asynchronously. After release, pulse stays 0 with no start.
- Burst: start with P=5, H=2, B=3 at edge k → pulse high on k..k+1, k+5..k+6, k+10..k+11. busy falls and done=1 exactly at k+15. pulse_cnt ends at 3.
- Continuous + stop: P=2, H=1, B=0, run 1000 cycles → 500 rising edges and 50% duty. stop → pulse=0 and busy=0 next edge, done never asserted, pulse_cnt=500 held.
- Config errors: start with (P=1, H=1), (P=4, H=0), (P=4, H=4) → cfg_err one cycle each, busy stays 0, pulse stays 0.
- Collisions:
  - start while busy: no effect on the waveform.
  - start+stop together in IDLE: no start.
  - start on the done cycle: ignored. start one cycle later: accepted.
- Extremes: P=3, H=2, B=1 → single 2-cycle pulse, done at k+3. P=2^16, H=1, B=2 → period measured exactly 65536 cycles.

Source files
------------

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: latches period/high-time/burst on start and emits
// a registered waveform for a fixed number of periods or continuously until stopped.
module pulse_gen #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [BURST_W-1:0] burst,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [BURST_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     high_q;
  logic [CNT_W-1:0]     low_q;
  logic [CNT_W-1:0]     ph_cnt_q;
  logic [BURST_W-1:0]   burst_q;
  logic [BURST_W-1:0]   per_cnt_q;
  logic [BURST_W-1:0]   pulse_cnt_q;
  logic                 pulse_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic                 cfg_ok;
  logic                 more_periods;

  assign cfg_ok = (period >= CNT_W'(2)) && (high_time != '0) && (high_time < period);

  // per_cnt_q never wraps in burst mode (it stops at burst_q), unlike pulse_cnt_q.
  assign more_periods = (burst_q == '0) || (per_cnt_q < burst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      high_q      <= '0;
      low_q       <= '0;
      ph_cnt_q    <= '0;
      burst_q     <= '0;
      per_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_ok) begin
              high_q      <= high_time;
              low_q       <= period - high_time;
              burst_q     <= burst;
              per_cnt_q   <= BURST_W'(1);
              pulse_cnt_q <= BURST_W'(1);
              ph_cnt_q    <= CNT_W'(1);
              pulse_q     <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= HIGH;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (stop) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (ph_cnt_q == high_q) begin
            state_q  <= LOW;
            pulse_q  <= 1'b0;
            ph_cnt_q <= CNT_W'(1);
          end else begin
            ph_cnt_q <= ph_cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (stop) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (ph_cnt_q == low_q) begin
            if (more_periods) begin
              state_q     <= HIGH;
              pulse_q     <= 1'b1;
              ph_cnt_q    <= CNT_W'(1);
              per_cnt_q   <= per_cnt_q + BURST_W'(1);
              pulse_cnt_q <= pulse_cnt_q + BURST_W'(1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            ph_cnt_q <= ph_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
